// File: rtl/cache_line_mover.sv
// Moves one 256-bit cache line between a data-array way and the 32-bit burst memory bus:
// refill (8 read beats -> array write) or writeback (array read -> 8 write beats).
module cache_line_mover #(
    parameter int unsigned SET_W  = 6,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [1:0]        req_way,
    input  logic [SET_W-1:0]  req_set,
    input  logic [31:0]       req_addr,
    output logic              done,
    output logic              err,
    output logic [WAYS-1:0]   da_wen,
    output logic [SET_W-1:0]  da_waddr,
    output logic [LINE_W-1:0] da_wdata,
    output logic [SET_W-1:0]  da_raddr,
    output logic [1:0]        da_rway,
    input  logic [LINE_W-1:0] da_rdata,
    output logic              mem_rd_req_valid,
    input  logic              mem_rd_req_ready,
    output logic [31:0]       mem_rd_addr,
    input  logic              mem_rd_rsp_valid,
    output logic              mem_rd_rsp_ready,
    input  logic [BEAT_W-1:0] mem_rd_rsp_data,
    input  logic              mem_rd_rsp_last,
    output logic              mem_wr_req_valid,
    input  logic              mem_wr_req_ready,
    output logic [31:0]       mem_wr_addr,
    output logic              mem_wr_data_valid,
    input  logic              mem_wr_data_ready,
    output logic [BEAT_W-1:0] mem_wr_data,
    output logic              mem_wr_last
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned IDX_W = $clog2(LINE_W);
    localparam int unsigned BOFF  = $clog2(BEAT_W);
    localparam logic [31:0] OFF_MASK = 32'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        StIdle, StRdReq, StRdBeat, StRdCommit, StWbLoad, StWrReq, StWrBeat, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         way_q, way_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [31:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  buf_q, buf_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               err_q, err_d;
    logic               last_beat;
    logic [IDX_W-1:0]   beat_lsb;

    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));
    assign beat_lsb  = IDX_W'(beat_cnt_q) << BOFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            way_q      <= '0;
            set_q      <= '0;
            addr_q     <= '0;
            buf_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            way_q      <= way_d;
            set_q      <= set_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        set_d      = set_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    way_d   = req_way;
                    set_d   = req_set;
                    addr_d  = req_addr & ~OFF_MASK;
                    state_d = req_op ? StWbLoad : StRdReq;
                end
            end
            StRdReq: begin
                if (mem_rd_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = StRdBeat;
                end
            end
            StRdBeat: begin
                if (mem_rd_rsp_valid) begin
                    buf_d[beat_lsb +: BEAT_W] = mem_rd_rsp_data;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    // The local beat count decides completion; a misplaced last only flags err.
                    if (mem_rd_rsp_last != last_beat) err_d = 1'b1;
                    if (last_beat) state_d = StRdCommit;
                end
            end
            StRdCommit: state_d = StDone;
            StWbLoad: begin
                buf_d   = da_rdata;
                state_d = StWrReq;
            end
            StWrReq: begin
                if (mem_wr_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = StWrBeat;
                end
            end
            StWrBeat: begin
                if (mem_wr_data_ready) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (last_beat) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // req_ready is gated by rst so it stays low for the whole reset window.
    assign req_ready         = (state_q == StIdle) && !rst;
    assign done              = (state_q == StDone);
    assign err               = err_q;
    assign da_wen            = (state_q == StRdCommit) ? (WAYS'(1) << way_q) : '0;
    assign da_waddr          = set_q;
    assign da_wdata          = buf_q;
    assign da_raddr          = set_q;
    assign da_rway           = way_q;
    assign mem_rd_req_valid  = (state_q == StRdReq);
    assign mem_rd_addr       = addr_q;
    assign mem_rd_rsp_ready  = (state_q == StRdBeat);
    assign mem_wr_req_valid  = (state_q == StWrReq);
    assign mem_wr_addr       = addr_q;
    assign mem_wr_data_valid = (state_q == StWrBeat);
    assign mem_wr_data       = buf_q[beat_lsb +: BEAT_W];
    assign mem_wr_last       = (state_q == StWrBeat) && last_beat;

endmodule

// File: tb/tb_cache_line_mover.sv
// Directed bench for cache_line_mover: background memory/array responder plus a
// linear sequence of refill, writeback, backpressure, err and reset scenarios.
module tb_cache_line_mover;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         req_valid, req_ready, req_op;
    logic [1:0]   req_way;
    logic [5:0]   req_set;
    logic [31:0]  req_addr;
    logic         done, err;
    logic [3:0]   da_wen;
    logic [5:0]   da_waddr, da_raddr;
    logic [255:0] da_wdata, da_rdata;
    logic [1:0]   da_rway;
    logic         mem_rd_req_valid;
    logic         mem_rd_req_ready = 1'b0;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_rsp_valid = 1'b0;
    logic         mem_rd_rsp_ready;
    logic [31:0]  mem_rd_rsp_data = '0;
    logic         mem_rd_rsp_last = 1'b0;
    logic         mem_wr_req_valid;
    logic         mem_wr_req_ready = 1'b0;
    logic [31:0]  mem_wr_addr;
    logic         mem_wr_data_valid;
    logic         mem_wr_data_ready = 1'b0;
    logic [31:0]  mem_wr_data;
    logic         mem_wr_last;

    cache_line_mover dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_way(req_way), .req_set(req_set), .req_addr(req_addr),
        .done(done), .err(err),
        .da_wen(da_wen), .da_waddr(da_waddr), .da_wdata(da_wdata),
        .da_raddr(da_raddr), .da_rway(da_rway), .da_rdata(da_rdata),
        .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_rsp_valid(mem_rd_rsp_valid), .mem_rd_rsp_ready(mem_rd_rsp_ready),
        .mem_rd_rsp_data(mem_rd_rsp_data), .mem_rd_rsp_last(mem_rd_rsp_last),
        .mem_wr_req_valid(mem_wr_req_valid), .mem_wr_req_ready(mem_wr_req_ready),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data_valid(mem_wr_data_valid), .mem_wr_data_ready(mem_wr_data_ready),
        .mem_wr_data(mem_wr_data), .mem_wr_last(mem_wr_last)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus knobs (written by the initial block only)
    logic [31:0]  rd_beats [8];
    int           rd_last_idx = 7;
    int           rd_req_delay = 0;
    bit           wr_toggle = 1'b0;
    logic [255:0] wb_line = '0;
    logic [5:0]   wb_set = '0;
    logic [1:0]   wb_way = '0;

    // Observations (written by the negedge process only)
    int           cyc = 0, rd_idx = 0, rd_wait = 0;
    int           accept_cnt = 0, accept_time = 0, done_cnt = 0, done_time = 0;
    int           commit_cnt = 0, stab_err = 0, rd_stall = 0, wr_stall = 0, wr_n = 0;
    logic [3:0]   last_wen = '0;
    logic [5:0]   last_waddr = '0;
    logic [255:0] last_wdata = '0;
    logic [31:0]  rd_addr_seen = '0, wr_addr_seen = '0;
    logic [31:0]  wr_got [16];
    logic         wr_last_got [16];
    bit           rd_pend = 1'b0, wr_pend = 1'b0;
    logic [31:0]  prev_addr = '0, prev_wdat = '0;
    logic         prev_wlast = 1'b0;

    // Array read mux model: only the expected way/set returns the line.
    always_comb da_rdata = (da_raddr == wb_set && da_rway == wb_way) ? wb_line : '0;

    always @(negedge clk) begin
        cyc++;
        if (mem_rd_req_valid) begin
            rd_idx = 0;
            if (rd_wait < rd_req_delay) begin
                mem_rd_req_ready = 1'b0;
                rd_wait++;
            end else begin
                mem_rd_req_ready = 1'b1;
            end
        end else begin
            mem_rd_req_ready = 1'b0;
            rd_wait = 0;
        end
        if (mem_rd_rsp_ready && rd_idx < 8) begin
            mem_rd_rsp_valid = 1'b1;
            mem_rd_rsp_data  = rd_beats[rd_idx];
            mem_rd_rsp_last  = (rd_idx == rd_last_idx);
            rd_idx++;
        end else begin
            mem_rd_rsp_valid = 1'b0;
            mem_rd_rsp_data  = '0;
            mem_rd_rsp_last  = 1'b0;
        end
        mem_wr_req_ready  = 1'b1;
        mem_wr_data_ready = wr_toggle ? ~mem_wr_data_ready : 1'b1;

        if (rst) begin
            rd_pend = 1'b0;
            wr_pend = 1'b0;
        end else begin
            if (rd_pend && !(mem_rd_req_valid && mem_rd_addr == prev_addr)) stab_err++;
            if (wr_pend && !(mem_wr_data_valid && mem_wr_data == prev_wdat &&
                             mem_wr_last == prev_wlast)) stab_err++;
            rd_pend    = mem_rd_req_valid && !mem_rd_req_ready;
            prev_addr  = mem_rd_addr;
            wr_pend    = mem_wr_data_valid && !mem_wr_data_ready;
            prev_wdat  = mem_wr_data;
            prev_wlast = mem_wr_last;
            if (rd_pend) rd_stall++;
            if (wr_pend) wr_stall++;
            if (mem_rd_req_valid && mem_rd_req_ready) rd_addr_seen = mem_rd_addr;
            if (mem_wr_req_valid && mem_wr_req_ready) begin
                wr_addr_seen = mem_wr_addr;
                wr_n = 0;
            end
            if (mem_wr_data_valid && mem_wr_data_ready && wr_n < 16) begin
                wr_got[wr_n]      = mem_wr_data;
                wr_last_got[wr_n] = mem_wr_last;
                wr_n++;
            end
            if (req_valid && req_ready) begin
                accept_cnt++;
                accept_time = cyc;
            end
        end
        if (da_wen != 4'b0) begin
            commit_cnt++;
            last_wen   = da_wen;
            last_waddr = da_waddr;
            last_wdata = da_wdata;
        end
        if (done) begin
            done_cnt++;
            done_time = cyc;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + step * i;
        return l;
    endfunction

    task automatic set_beats(input logic [31:0] base, input logic [31:0] step);
        for (int i = 0; i < 8; i++) rd_beats[i] = base + step * i;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_req(input logic op, input logic [1:0] way, input logic [5:0] set,
                          input logic [31:0] addr);
        req_op = op; req_way = way; req_set = set; req_addr = addr; req_valid = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 300 && done_cnt < target; i++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    int c0, d0, a0, s0, d1t;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_way = '0; req_set = '0; req_addr = '0;
        set_beats(32'h0, 32'h0);
        #22;
        chk("rst_ctrl_zero", {req_ready, done, err, da_wen, mem_rd_req_valid, mem_rd_rsp_ready,
                              mem_wr_req_valid, mem_wr_data_valid, mem_wr_last}, '0);
        chk("rst_addr_zero", {mem_rd_addr, mem_wr_addr, mem_wr_data, da_waddr, da_raddr, da_rway},
            '0);
        chk("rst_wdata_zero", da_wdata, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", req_ready, 1'b1);

        // Refill, way 2, set 0x15
        c0 = commit_cnt; d0 = done_cnt; a0 = accept_cnt;
        set_beats(32'h11, 32'h11); rd_last_idx = 7;
        do_req(1'b0, 2'd2, 6'h15, 32'h8000_1234);
        wait_done(d0 + 1);
        chk("rf_rd_addr", rd_addr_seen, 32'h8000_1220);
        chk("rf_accepts", accept_cnt - a0, 1);
        chk("rf_commits", commit_cnt - c0, 1);
        chk("rf_wen", last_wen, 4'b0100);
        chk("rf_waddr", last_waddr, 6'h15);
        chk("rf_wdata", last_wdata, mk_line(32'h11, 32'h11));
        chk("rf_latency", done_time - accept_time, 11);
        chk("rf_err", err, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        chk("rf_done_once", done_cnt - d0, 1);

        // Writeback, way 0, set 63
        c0 = commit_cnt; d0 = done_cnt;
        wb_line = mk_line(32'hA0, 32'h1); wb_set = 6'd63; wb_way = 2'd0;
        do_req(1'b1, 2'd0, 6'd63, 32'h0000_101F);
        wait_done(d0 + 1);
        chk("wb_addr", wr_addr_seen, 32'h0000_1000);
        chk("wb_beats", wr_n, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wb_data%0d", i), wr_got[i], 32'hA0 + i);
            chk($sformatf("wb_last%0d", i), wr_last_got[i], (i == 7));
        end
        chk("wb_no_commit", commit_cnt - c0, 0);
        chk("wb_latency", done_time - accept_time, 11);

        // Backpressure: read request delayed 5 cycles, then toggling write-data ready
        c0 = commit_cnt; d0 = done_cnt; s0 = rd_stall;
        set_beats(32'hD0, 32'h1); rd_req_delay = 5;
        do_req(1'b0, 2'd1, 6'h2A, 32'h1234_5678);
        wait_done(d0 + 1);
        rd_req_delay = 0;
        chk("bp_rd_stall", rd_stall - s0, 5);
        chk("bp_rd_addr", rd_addr_seen, 32'h1234_5660);
        chk("bp_rd_wdata", last_wdata, mk_line(32'hD0, 32'h1));
        chk("bp_rd_wen", last_wen, 4'b0010);
        chk("bp_rd_latency", done_time - accept_time, 16);
        d0 = done_cnt; s0 = wr_stall;
        wb_line = mk_line(32'hB0, 32'h1); wb_set = 6'd9; wb_way = 2'd3; wr_toggle = 1'b1;
        do_req(1'b1, 2'd3, 6'd9, 32'h4000_0000);
        wait_done(d0 + 1);
        wr_toggle = 1'b0;
        chk("bp_wr_stalled", wr_stall - s0 > 0, 1'b1);
        chk("bp_wr_beats", wr_n, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_wr_data%0d", i), wr_got[i], 32'hB0 + i);
        chk("bp_wr_last7", wr_last_got[7], 1'b1);
        chk("bp_stable", stab_err, 0);
        chk("bp_done_once", done_cnt - d0, 1);

        // Early last on beat 5: err sticks, line still committed
        c0 = commit_cnt; d0 = done_cnt;
        set_beats(32'h100, 32'h1); rd_last_idx = 4;
        do_req(1'b0, 2'd1, 6'd3, 32'h0000_2000);
        wait_done(d0 + 1);
        rd_last_idx = 7;
        chk("el_err", err, 1'b1);
        chk("el_commit", commit_cnt - c0, 1);
        chk("el_wdata", last_wdata, mk_line(32'h100, 32'h1));
        d0 = done_cnt;
        set_beats(32'h140, 32'h1);
        do_req(1'b0, 2'd0, 6'd4, 32'h0000_2100);
        wait_done(d0 + 1);
        chk("el_err_sticky", err, 1'b1);

        // Reset in the middle of a refill
        c0 = commit_cnt; d0 = done_cnt;
        set_beats(32'h200, 32'h1);
        do_req(1'b0, 2'd3, 6'd7, 32'h0000_3000);
        for (int i = 0; i < 50 && rd_idx != 5; i++) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        chk("mr_rsp_ready", mem_rd_rsp_ready, 1'b0);
        chk("mr_req_ready", req_ready, 1'b0);
        chk("mr_err_clr", err, 1'b0);
        chk("mr_outs", {da_wen, done, mem_rd_addr, da_waddr}, '0);
        chk("mr_wdata", da_wdata, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("mr_no_commit", commit_cnt - c0, 0);
        chk("mr_no_done", done_cnt - d0, 0);
        set_beats(32'h300, 32'h1);
        @(posedge clk); #1;
        do_req(1'b0, 2'd3, 6'd7, 32'h0000_3000);
        wait_done(d0 + 1);
        chk("mr_fresh_commit", commit_cnt - c0, 1);
        chk("mr_fresh_wen", last_wen, 4'b1000);
        chk("mr_fresh_waddr", last_waddr, 6'd7);
        chk("mr_fresh_wdata", last_wdata, mk_line(32'h300, 32'h1));
        chk("mr_fresh_err", err, 1'b0);

        // req_valid held high: one acceptance per IDLE visit, back-to-back
        a0 = accept_cnt; d0 = done_cnt;
        set_beats(32'h400, 32'h1);
        req_op = 1'b0; req_way = 2'd0; req_set = 6'd1; req_addr = 32'h0000_5000;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && done_cnt < d0 + 1; i++) begin @(posedge clk); #1; end
        d1t = done_time;
        chk("hv_one_accept", accept_cnt - a0, 1);
        for (int i = 0; i < 20 && accept_cnt < a0 + 2; i++) begin @(posedge clk); #1; end
        req_valid = 1'b0;
        chk("hv_b2b_accept", accept_time - d1t, 1);
        wait_done(d0 + 2);
        chk("hv_two_accepts", accept_cnt - a0, 2);
        chk("hv_two_dones", done_cnt - d0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
